// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: shared instruction-cache configuration plus refill scheduler types.
package snitch_icache_pkg;

   typedef struct packed {
      int unsigned FETCH_AW;
      int unsigned LINE_WIDTH;
      int unsigned LINE_ALIGN;
      int unsigned COUNT_ALIGN;
      int unsigned TAG_WIDTH;
      int unsigned SET_COUNT;
      int unsigned SET_ALIGN;
   } config_t;

   localparam config_t DEFAULT_CFG = '{
      FETCH_AW: 32, LINE_WIDTH: 64, LINE_ALIGN: 4, COUNT_ALIGN: 4,
      TAG_WIDTH: 24, SET_COUNT: 4, SET_ALIGN: 2
   };

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, ACK} refill_sched_state_e;

   localparam int unsigned REPL_RR = 0;
   localparam int unsigned REPL_LFSR = 1;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois LFSR: feedback from bit 0 is folded into the tap positions.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/snitch_icache_victim_sel.sv
// snitch_icache_victim_sel: picks the set a refilled line is written to,
// either round-robin or pseudo-random, advancing once per line written.
module snitch_icache_victim_sel import snitch_icache_pkg::*; #(
   parameter int unsigned SET_COUNT = 4,
   parameter int unsigned SET_ALIGN = 2,
   parameter int unsigned REPLACE = REPL_RR
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 advance,
   input  logic                 clear,
   output logic [SET_ALIGN-1:0] victim
);

   if (SET_COUNT <= 1) begin : gen_single
      logic unused_in;
      assign unused_in = ^{clk_i, rst_ni, advance, clear};
      assign victim = '0;
   end else if (REPLACE == REPL_LFSR) begin : gen_lfsr
      // The LFSR deliberately survives flushes; only reset reseeds it.
      logic [15:0] lfsr_q;
      logic unused_clear;
      assign unused_clear = clear;
      always_ff @(posedge clk_i or negedge rst_ni)
         if (!rst_ni) lfsr_q <= LFSR_SEED;
         else if (advance) lfsr_q <= lfsr_step(lfsr_q);
      assign victim = SET_ALIGN'(32'(lfsr_q[SET_ALIGN-1:0]) % SET_COUNT);
   end else begin : gen_rr
      logic [SET_ALIGN-1:0] cnt_q;
      always_ff @(posedge clk_i or negedge rst_ni)
         if (!rst_ni) cnt_q <= '0;
         else if (clear) cnt_q <= '0;
         else if (advance) cnt_q <= (cnt_q == SET_ALIGN'(SET_COUNT - 1)) ? '0 : cnt_q + SET_ALIGN'(1);
      assign victim = cnt_q;
   end

endmodule

// File: rtl/snitch_icache_refill_sched.sv
// snitch_icache_refill_sched: buffers returning line refills, splits them into index/tag,
// picks a victim set and writes them into the lookup; also sequences cache flushes.
module snitch_icache_refill_sched import snitch_icache_pkg::*; #(
   parameter config_t     CFG        = DEFAULT_CFG,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned REPLACE    = REPL_RR
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [CFG.FETCH_AW-1:0]    refill_addr_i,
   input  logic [CFG.LINE_WIDTH-1:0]  refill_data_i,
   input  logic                       refill_error_i,
   input  logic                       refill_valid_i,
   output logic                       refill_ready_o,
   output logic [CFG.COUNT_ALIGN-1:0] write_addr_o,
   output logic [CFG.SET_ALIGN-1:0]   write_set_o,
   output logic [CFG.LINE_WIDTH-1:0]  write_data_o,
   output logic [CFG.TAG_WIDTH-1:0]   write_tag_o,
   output logic                       write_error_o,
   output logic                       write_valid_o,
   input  logic                       write_ready_i,
   input  logic                       flush_valid_i,
   output logic                       flush_ready_o,
   output logic                       lookup_flush_valid_o,
   input  logic                       lookup_flush_ready_i,
   output logic                       busy_o
);

   localparam int unsigned PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [CFG.COUNT_ALIGN-1:0] index;
      logic [CFG.TAG_WIDTH-1:0]   tag;
      logic [CFG.LINE_WIDTH-1:0]  data;
      logic                       error;
   } entry_t;

   entry_t              mem_q [FIFO_DEPTH];
   logic [PW-1:0]       rd_q, wr_q;
   logic [CW-1:0]       cnt_q;
   refill_sched_state_e state_q;
   logic                push, pop, empty, full;
   logic [CFG.LINE_ALIGN-1:0] unused_offset;

   assign unused_offset  = refill_addr_i[CFG.LINE_ALIGN-1:0];
   assign empty          = cnt_q == '0;
   assign full           = cnt_q == DEPTH;
   assign refill_ready_o = !full && state_q == IDLE && !flush_valid_i;
   assign push           = refill_valid_i && refill_ready_o;
   assign write_valid_o  = !empty;
   assign pop            = write_valid_o && write_ready_i;
   assign busy_o         = !empty || state_q != IDLE;
   assign {write_addr_o, write_tag_o, write_data_o, write_error_o} = mem_q[rd_q];

   // Storage carries no reset: an empty count already makes stale entries invisible.
   always_ff @(posedge clk_i)
      if (push) mem_q[wr_q] <= '{
         index: refill_addr_i[CFG.LINE_ALIGN +: CFG.COUNT_ALIGN],
         tag:   refill_addr_i[CFG.FETCH_AW-1 : CFG.LINE_ALIGN+CFG.COUNT_ALIGN],
         data:  refill_data_i,
         error: refill_error_i
      };

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q == LAST ? '0 : wr_q + PW'(1);
         if (pop) rd_q <= rd_q == LAST ? '0 : rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q              <= IDLE;
         lookup_flush_valid_o <= 1'b0;
         flush_ready_o        <= 1'b0;
      end else begin
         case (state_q)
            IDLE:  if (flush_valid_i) state_q <= DRAIN;
            DRAIN: if (empty) begin
               state_q              <= FLUSH;
               lookup_flush_valid_o <= 1'b1;
            end
            FLUSH: if (lookup_flush_ready_i) begin
               state_q              <= ACK;
               lookup_flush_valid_o <= 1'b0;
               flush_ready_o        <= 1'b1;
            end
            default: begin
               state_q       <= IDLE;
               flush_ready_o <= 1'b0;
            end
         endcase
      end

   snitch_icache_victim_sel #(
      .SET_COUNT (CFG.SET_COUNT),
      .SET_ALIGN (CFG.SET_ALIGN),
      .REPLACE   (REPLACE)
   ) i_victim_sel (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .advance (pop),
      .clear   (state_q == ACK),
      .victim  (write_set_o)
   );

endmodule

// File: tb/tb_snitch_icache_refill_sched.sv
// tb_snitch_icache_refill_sched: round-robin and LFSR schedulers driven by shared stimulus,
// checked against a queue-based reference model of refill buffering and flush sequencing.
module tb_snitch_icache_refill_sched;
   import snitch_icache_pkg::*;

   localparam config_t CFG = '{
      FETCH_AW: 32, LINE_WIDTH: 64, LINE_ALIGN: 4, COUNT_ALIGN: 4,
      TAG_WIDTH: 24, SET_COUNT: 4, SET_ALIGN: 2
   };

   logic clk_i = 1'b0, rst_ni = 1'b0;
   logic [31:0] refill_addr_i = '0;
   logic [63:0] refill_data_i = '0;
   logic refill_error_i = 1'b0, refill_valid_i = 1'b0, write_ready_i = 1'b0;
   logic flush_valid_i = 1'b0, lookup_flush_ready_i = 1'b0;

   logic r_refill_ready, r_write_error, r_write_valid, r_flush_ready, r_lookup_flush_valid, r_busy;
   logic l_refill_ready, l_write_error, l_write_valid, l_flush_ready, l_lookup_flush_valid, l_busy;
   logic [3:0]  r_write_addr, l_write_addr;
   logic [1:0]  r_write_set, l_write_set;
   logic [63:0] r_write_data, l_write_data;
   logic [23:0] r_write_tag, l_write_tag;

   int checks = 0, errors = 0;

   always #5 clk_i = ~clk_i;

   snitch_icache_refill_sched #(.CFG(CFG), .FIFO_DEPTH(2), .REPLACE(0)) dut_r (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .refill_addr_i(refill_addr_i), .refill_data_i(refill_data_i), .refill_error_i(refill_error_i),
      .refill_valid_i(refill_valid_i), .refill_ready_o(r_refill_ready),
      .write_addr_o(r_write_addr), .write_set_o(r_write_set), .write_data_o(r_write_data),
      .write_tag_o(r_write_tag), .write_error_o(r_write_error), .write_valid_o(r_write_valid),
      .write_ready_i(write_ready_i), .flush_valid_i(flush_valid_i), .flush_ready_o(r_flush_ready),
      .lookup_flush_valid_o(r_lookup_flush_valid), .lookup_flush_ready_i(lookup_flush_ready_i),
      .busy_o(r_busy)
   );

   snitch_icache_refill_sched #(.CFG(CFG), .FIFO_DEPTH(2), .REPLACE(1)) dut_l (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .refill_addr_i(refill_addr_i), .refill_data_i(refill_data_i), .refill_error_i(refill_error_i),
      .refill_valid_i(refill_valid_i), .refill_ready_o(l_refill_ready),
      .write_addr_o(l_write_addr), .write_set_o(l_write_set), .write_data_o(l_write_data),
      .write_tag_o(l_write_tag), .write_error_o(l_write_error), .write_valid_o(l_write_valid),
      .write_ready_i(write_ready_i), .flush_valid_i(flush_valid_i), .flush_ready_o(l_flush_ready),
      .lookup_flush_valid_o(l_lookup_flush_valid), .lookup_flush_ready_i(lookup_flush_ready_i),
      .busy_o(l_busy)
   );

   // Reference model: a queue of pending lines, the flush progress (0 idle, 1 draining,
   // 2 waiting on lookup, 3 acknowledging) and both victim policies.
   typedef struct packed {
      logic [3:0]  idx;
      logic [23:0] tag;
      logic [63:0] data;
      logic        err;
   } ent_t;

   ent_t q[$];
   int phase = 0, rr = 0;
   logic [15:0] lfsr = 16'hACE1;

   function automatic ent_t split(input logic [31:0] a, input logic [63:0] d, input logic e);
      return '{idx: 4'((a >> 4) % 16), tag: 24'(a >> 8), data: d, err: e};
   endfunction

   always @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         q.delete();
         phase <= 0;
         rr <= 0;
         lfsr <= 16'hACE1;
      end else begin
         automatic int n = q.size();
         automatic bit do_push = refill_valid_i && n < 2 && phase == 0 && !flush_valid_i;
         if (n != 0 && write_ready_i) begin
            q.delete(0);
            rr <= (rr + 1) % 4;
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         end
         if (do_push) q.push_back(split(refill_addr_i, refill_data_i, refill_error_i));
         if (phase == 0 && flush_valid_i) phase <= 1;
         else if (phase == 1 && n == 0) phase <= 2;
         else if (phase == 2 && lookup_flush_ready_i) phase <= 3;
         else if (phase == 3) begin
            phase <= 0;
            rr <= 0;
         end
      end

   function automatic logic [97:0] exp_vec();
      ent_t h = q.size() != 0 ? q[0] : '0;
      return {q.size() < 2 && phase == 0 && !flush_valid_i, q.size() != 0, h,
              phase == 3, phase == 2, q.size() != 0 || phase != 0};
   endfunction

   function automatic logic [97:0] obs_r();
      return {r_refill_ready, r_write_valid,
              r_write_valid ? {r_write_addr, r_write_tag, r_write_data, r_write_error} : 93'b0,
              r_flush_ready, r_lookup_flush_valid, r_busy};
   endfunction

   function automatic logic [97:0] obs_l();
      return {l_refill_ready, l_write_valid,
              l_write_valid ? {l_write_addr, l_write_tag, l_write_data, l_write_error} : 93'b0,
              l_flush_ready, l_lookup_flush_valid, l_busy};
   endfunction

   task automatic do_reset();
      refill_valid_i = 0; write_ready_i = 0; flush_valid_i = 0; lookup_flush_ready_i = 0;
      rst_ni = 0;
      @(posedge clk_i); #1 rst_ni = 1;
   endtask

   task automatic test_reset();
      rst_ni = 0;
      #2;
      checks++; if (r_refill_ready !== 1'b1) begin errors++; $display("FAIL reset_refill_ready got %b exp 1", r_refill_ready); end
      checks++; if (r_write_valid !== 1'b0) begin errors++; $display("FAIL reset_write_valid got %b exp 0", r_write_valid); end
      checks++; if (r_flush_ready !== 1'b0) begin errors++; $display("FAIL reset_flush_ready got %b exp 0", r_flush_ready); end
      checks++; if (r_lookup_flush_valid !== 1'b0) begin errors++; $display("FAIL reset_lookup_flush got %b exp 0", r_lookup_flush_valid); end
      checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", r_busy); end
      checks++; if (l_write_valid !== 1'b0 || l_busy !== 1'b0) begin errors++; $display("FAIL reset_lfsr_dut got valid %b busy %b exp 0 0", l_write_valid, l_busy); end
      @(posedge clk_i); #1 rst_ni = 1;
   endtask

   task automatic test_single();
      logic [63:0] d = {$urandom, $urandom};
      do_reset();
      write_ready_i = 1; refill_addr_i = 32'h0000_1230; refill_data_i = d; refill_error_i = 0; refill_valid_i = 1;
      @(negedge clk_i);
      checks++; if (r_refill_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", r_refill_ready); end
      checks++; if (r_write_valid !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough got %b exp 0", r_write_valid); end
      @(posedge clk_i); #1 refill_valid_i = 0;
      @(negedge clk_i);
      checks++; if (r_write_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", r_write_valid); end
      checks++; if (r_write_addr !== 4'h3) begin errors++; $display("FAIL single_index got %h exp 3", r_write_addr); end
      checks++; if (r_write_tag !== 24'h000012) begin errors++; $display("FAIL single_tag got %h exp 000012", r_write_tag); end
      checks++; if (r_write_set !== 2'd0) begin errors++; $display("FAIL single_set got %0d exp 0", r_write_set); end
      checks++; if (r_write_data !== d) begin errors++; $display("FAIL single_data got %h exp %h", r_write_data, d); end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checks++; if (r_write_valid !== 1'b0 || r_busy !== 1'b0) begin errors++; $display("FAIL single_popped got valid %b busy %b exp 0 0", r_write_valid, r_busy); end
      write_ready_i = 0;
   endtask

   task automatic test_back_to_back();
      logic [1:0] sets[$];
      logic [1:0] exp_sets [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      write_ready_i = 1; refill_valid_i = 1;
      for (int i = 0; i < 8; i++) begin
         if (i < 6) begin
            refill_addr_i = $urandom; refill_data_i = {$urandom, $urandom}; refill_error_i = 1'($urandom);
         end else refill_valid_i = 0;
         @(negedge clk_i);
         if (i < 6) begin
            checks++; if (r_refill_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, r_refill_ready); end
         end
         checks++; if (obs_r() !== exp_vec()) begin errors++; $display("FAIL b2b_outputs[%0d] got %h exp %h", i, obs_r(), exp_vec()); end
         if (r_write_valid) begin
            sets.push_back(r_write_set);
            checks++; if (l_write_set !== lfsr[1:0]) begin errors++; $display("FAIL b2b_lfsr_set[%0d] got %0d exp %0d", i, l_write_set, lfsr[1:0]); end
         end
         @(posedge clk_i); #1;
      end
      checks++; if (sets.size() != 6) begin errors++; $display("FAIL b2b_write_count got %0d exp 6", sets.size()); end
      for (int j = 0; j < 6 && j < sets.size(); j++) begin
         checks++; if (sets[j] !== exp_sets[j]) begin errors++; $display("FAIL b2b_set_seq[%0d] got %0d exp %0d", j, sets[j], exp_sets[j]); end
      end
      write_ready_i = 0;
   endtask

   task automatic test_stall();
      ent_t a[3];
      do_reset();
      refill_valid_i = 1;
      for (int i = 0; i < 3; i++) begin
         refill_addr_i = $urandom; refill_data_i = {$urandom, $urandom}; refill_error_i = 1'($urandom);
         a[i] = split(refill_addr_i, refill_data_i, refill_error_i);
         @(negedge clk_i);
         checks++; if (r_refill_ready !== (i < 2)) begin errors++; $display("FAIL stall_ready[%0d] got %b exp %b", i, r_refill_ready, i < 2); end
         @(posedge clk_i); #1;
      end
      refill_valid_i = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         checks++;
         if (r_write_valid !== 1'b1 || {r_write_addr, r_write_tag, r_write_data, r_write_error} !== a[0] || r_write_set !== 2'd0) begin
            errors++; $display("FAIL stall_hold[%0d] got v%b %h s%0d exp v1 %h s0", i, r_write_valid,
               {r_write_addr, r_write_tag, r_write_data, r_write_error}, r_write_set, a[0]);
         end
         @(posedge clk_i); #1;
      end
      write_ready_i = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         checks++;
         if (r_write_valid !== 1'b1 || {r_write_addr, r_write_tag, r_write_data, r_write_error} !== a[i] || r_write_set !== 2'(i)) begin
            errors++; $display("FAIL stall_drain[%0d] got v%b %h s%0d exp v1 %h s%0d", i, r_write_valid,
               {r_write_addr, r_write_tag, r_write_data, r_write_error}, r_write_set, a[i], i);
         end
         @(posedge clk_i); #1;
      end
      write_ready_i = 0;
      @(negedge clk_i);
      checks++; if (r_write_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b exp 0", r_write_valid); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_flush();
      do_reset();
      refill_addr_i = $urandom; refill_data_i = {$urandom, $urandom}; refill_valid_i = 1;
      @(posedge clk_i); #1 refill_valid_i = 0; flush_valid_i = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         checks++;
         if (r_refill_ready !== 1'b0 || r_lookup_flush_valid !== 1'b0 || r_write_valid !== 1'b1 || r_busy !== 1'b1) begin
            errors++; $display("FAIL flush_drain[%0d] got rdy %b lfv %b wv %b busy %b exp 0 0 1 1", i,
               r_refill_ready, r_lookup_flush_valid, r_write_valid, r_busy);
         end
         @(posedge clk_i); #1;
      end
      write_ready_i = 1;
      @(negedge clk_i);
      checks++; if (r_lookup_flush_valid !== 1'b0 || r_refill_ready !== 1'b0) begin errors++; $display("FAIL flush_pop_cycle got lfv %b rdy %b exp 0 0", r_lookup_flush_valid, r_refill_ready); end
      @(posedge clk_i); #1 write_ready_i = 0;
      @(negedge clk_i);
      checks++; if (r_lookup_flush_valid !== 1'b0 || r_write_valid !== 1'b0 || r_busy !== 1'b1) begin errors++; $display("FAIL flush_empty got lfv %b wv %b busy %b exp 0 0 1", r_lookup_flush_valid, r_write_valid, r_busy); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1 lookup_flush_ready_i = (i == 2);
         @(negedge clk_i);
         checks++; if (r_lookup_flush_valid !== 1'b1 || r_flush_ready !== 1'b0) begin errors++; $display("FAIL flush_lookup[%0d] got lfv %b fr %b exp 1 0", i, r_lookup_flush_valid, r_flush_ready); end
      end
      @(posedge clk_i); #1 lookup_flush_ready_i = 0; flush_valid_i = 0;
      @(negedge clk_i);
      checks++; if (r_flush_ready !== 1'b1 || r_lookup_flush_valid !== 1'b0) begin errors++; $display("FAIL flush_ack got fr %b lfv %b exp 1 0", r_flush_ready, r_lookup_flush_valid); end
      @(posedge clk_i); #1 refill_valid_i = 1; write_ready_i = 1; refill_addr_i = $urandom;
      @(negedge clk_i);
      checks++; if (r_flush_ready !== 1'b0 || r_refill_ready !== 1'b1 || r_busy !== 1'b0) begin errors++; $display("FAIL flush_idle got fr %b rdy %b busy %b exp 0 1 0", r_flush_ready, r_refill_ready, r_busy); end
      @(posedge clk_i); #1 refill_valid_i = 0;
      @(negedge clk_i);
      checks++; if (r_write_valid !== 1'b1 || r_write_set !== 2'd0) begin errors++; $display("FAIL flush_set_cleared got v%b s%0d exp v1 s0", r_write_valid, r_write_set); end
      checks++; if (l_write_set !== lfsr[1:0]) begin errors++; $display("FAIL flush_lfsr_kept got %0d exp %0d", l_write_set, lfsr[1:0]); end
      @(posedge clk_i); #1 write_ready_i = 0;
   endtask

   task automatic test_flush_priority();
      ent_t e;
      do_reset();
      refill_addr_i = $urandom; refill_data_i = {$urandom, $urandom}; refill_error_i = 0;
      e = split(refill_addr_i, refill_data_i, refill_error_i);
      lookup_flush_ready_i = 1; flush_valid_i = 1; refill_valid_i = 1; write_ready_i = 0;
      for (int i = 0; i < 8 && flush_valid_i; i++) begin
         @(negedge clk_i);
         checks++; if (r_refill_ready !== 1'b0 || r_write_valid !== 1'b0) begin errors++; $display("FAIL prio_blocked[%0d] got rdy %b wv %b exp 0 0", i, r_refill_ready, r_write_valid); end
         @(posedge clk_i); #1 if (r_flush_ready === 1'b1) flush_valid_i = 0;
      end
      checks++; if (flush_valid_i !== 1'b0) begin errors++; $display("FAIL prio_ack_timeout got no flush ack exp ack within 8 cycles"); end
      flush_valid_i = 0;
      @(negedge clk_i);
      checks++; if (r_flush_ready !== 1'b1 || r_refill_ready !== 1'b0) begin errors++; $display("FAIL prio_ack got fr %b rdy %b exp 1 0", r_flush_ready, r_refill_ready); end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checks++; if (r_refill_ready !== 1'b1) begin errors++; $display("FAIL prio_accept got %b exp 1", r_refill_ready); end
      @(posedge clk_i); #1 refill_valid_i = 0; lookup_flush_ready_i = 0;
      @(negedge clk_i);
      checks++; if (r_write_valid !== 1'b1 || {r_write_addr, r_write_tag, r_write_data, r_write_error} !== e) begin
         errors++; $display("FAIL prio_entry got v%b %h exp v1 %h", r_write_valid, {r_write_addr, r_write_tag, r_write_data, r_write_error}, e);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         refill_valid_i = ($urandom % 3) != 0;
         refill_addr_i = $urandom; refill_data_i = {$urandom, $urandom}; refill_error_i = 1'($urandom);
         write_ready_i = ($urandom % 4) != 0;
         lookup_flush_ready_i = 1'($urandom);
         if (flush_valid_i && r_flush_ready) flush_valid_i = 0;
         else if (!flush_valid_i) flush_valid_i = ($urandom % 25) == 0;
         @(negedge clk_i);
         checks++; if (obs_r() !== exp_vec()) begin errors++; $display("FAIL rand_rr_outputs[%0d] got %h exp %h", i, obs_r(), exp_vec()); end
         checks++; if (obs_l() !== exp_vec()) begin errors++; $display("FAIL rand_lfsr_outputs[%0d] got %h exp %h", i, obs_l(), exp_vec()); end
         if (q.size() != 0) begin
            checks++; if (r_write_set !== 2'(rr)) begin errors++; $display("FAIL rand_rr_set[%0d] got %0d exp %0d", i, r_write_set, rr); end
            checks++; if (l_write_set !== lfsr[1:0]) begin errors++; $display("FAIL rand_lfsr_set[%0d] got %0d exp %0d", i, l_write_set, lfsr[1:0]); end
         end
         @(posedge clk_i); #1;
      end
      refill_valid_i = 0; flush_valid_i = 0; lookup_flush_ready_i = 0;
   endtask

   task automatic test_lfsr_reset();
      logic [1:0] sets[$];
      logic [1:0] exp_sets [4] = '{2'd1, 2'd0, 2'd0, 2'd0};
      do_reset();
      write_ready_i = 1; refill_valid_i = 1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin refill_addr_i = $urandom; refill_data_i = {$urandom, $urandom}; end
         else refill_valid_i = 0;
         @(negedge clk_i);
         if (l_write_valid) sets.push_back(l_write_set);
         @(posedge clk_i); #1;
      end
      checks++; if (sets.size() != 4) begin errors++; $display("FAIL lfsr_write_count got %0d exp 4", sets.size()); end
      for (int j = 0; j < 4 && j < sets.size(); j++) begin
         checks++; if (sets[j] !== exp_sets[j]) begin errors++; $display("FAIL lfsr_set_seq[%0d] got %0d exp %0d", j, sets[j], exp_sets[j]); end
      end
      write_ready_i = 0; refill_valid_i = 1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1 refill_valid_i = 0;
      @(negedge clk_i);
      checks++; if (r_write_valid !== 1'b1 || l_busy !== 1'b1) begin errors++; $display("FAIL midreset_pending got wv %b busy %b exp 1 1", r_write_valid, l_busy); end
      rst_ni = 0;
      #1;
      checks++; if (r_write_valid !== 1'b0 || l_write_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b %b exp 0 0", r_write_valid, l_write_valid); end
      checks++; if (r_busy !== 1'b0 || l_busy !== 1'b0 || r_refill_ready !== 1'b1) begin errors++; $display("FAIL midreset_state got busy %b %b rdy %b exp 0 0 1", r_busy, l_busy, r_refill_ready); end
      @(posedge clk_i); #1 rst_ni = 1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_flush();
      test_flush_priority();
      test_random();
      test_lfsr_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
